// File: rtl/branch_seq_pkg.sv
// Shared types, FSM state encoding and opcode predicates for branch_seq.
package opcodes;

    typedef logic [31:0] instruction_t;
    typedef logic [31:0] register_t;

    // An instruction pattern matches when (instr & mask) == match.
    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] match;
    } insn_pattern_t;

    localparam insn_pattern_t M_JAL  = '{mask: 32'h0000_007F, match: 32'h0000_006F};
    localparam insn_pattern_t M_JALR = '{mask: 32'h0000_707F, match: 32'h0000_0067};
    localparam insn_pattern_t M_BEQ  = '{mask: 32'h0000_707F, match: 32'h0000_0063};
    localparam insn_pattern_t M_BNE  = '{mask: 32'h0000_707F, match: 32'h0000_1063};
    localparam insn_pattern_t M_BLT  = '{mask: 32'h0000_707F, match: 32'h0000_4063};
    localparam insn_pattern_t M_BGE  = '{mask: 32'h0000_707F, match: 32'h0000_5063};
    localparam insn_pattern_t M_BLTU = '{mask: 32'h0000_707F, match: 32'h0000_6063};
    localparam insn_pattern_t M_BGEU = '{mask: 32'h0000_707F, match: 32'h0000_7063};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RESOLVE,
        S_FLUSH,
        S_WB
    } seq_state_t;

    function automatic logic insn_match(input instruction_t instr, input insn_pattern_t pat);
        return (instr & pat.mask) == pat.match;
    endfunction

    // Any instruction that can change the PC other than by +4.
    function automatic logic is_ctrl(input instruction_t instr);
        return insn_match(instr, M_JAL)  || insn_match(instr, M_JALR) ||
               insn_match(instr, M_BEQ)  || insn_match(instr, M_BNE)  ||
               insn_match(instr, M_BLT)  || insn_match(instr, M_BGE)  ||
               insn_match(instr, M_BLTU) || insn_match(instr, M_BGEU);
    endfunction

    // Jumps that write a link address to a real register (x0 discards it).
    function automatic logic is_link(input instruction_t instr);
        return (insn_match(instr, M_JAL) || insn_match(instr, M_JALR)) &&
               (instr[11:7] != 5'd0);
    endfunction

    // The flush counter is 4 bits wide and must run at least one cycle.
    function automatic logic flush_cycles_legal(input int n);
        return (n >= 1) && (n <= 15);
    endfunction

endpackage

// File: rtl/branch_seq_sat_counter.sv
// Saturating up-counter used for the performance monitors.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] FULL = {W{1'b1}};

    logic [W-1:0] count_reg;

    // Count up on inc, hold at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != FULL)) begin
            count_reg <= count_reg + ONE;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/branch_seq.sv
// Control sequencer between decode and branch_unit: issues one instruction,
// resolves taken/not-taken, redirects and flushes fetch, and writes back links.
module branch_seq
    import opcodes::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  instruction_t       in_instr,
    input  register_t          in_op1,
    input  register_t          in_op2,
    input  register_t          in_op3,
    output logic               bu_enable,
    output instruction_t       bu_instr,
    output register_t          bu_op1,
    output register_t          bu_op2,
    output register_t          bu_op3,
    input  logic [31:0]        bu_pc,
    input  logic [31:0]        bu_ret_addr,
    output logic               fetch_redirect,
    output logic [31:0]        fetch_target,
    output logic               fetch_flush,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [4:0]         wb_rd,
    output logic [31:0]        wb_data,
    output logic               misalign_err,
    output logic [CNT_W-1:0]   retire_cnt,
    output logic [CNT_W-1:0]   taken_cnt
);

    generate
        if (!flush_cycles_legal(FLUSH_CYCLES)) begin : g_bad_flush_cycles
            $error("branch_seq: FLUSH_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    seq_state_t   state_reg, state_next;
    logic [3:0]   flush_cnt_reg, flush_cnt_next;
    logic [31:0]  fetch_target_reg, fetch_target_next;
    logic         fetch_redirect_reg, fetch_redirect_next;
    logic [31:0]  wb_data_reg, wb_data_next;

    instruction_t instr_reg;
    register_t    op1_reg, op2_reg, op3_reg;
    logic [31:0]  start_pc_reg;
    logic         is_link_reg;
    logic         is_ctrl_reg;

    logic         accept;
    logic         misaligned;
    logic         taken;
    logic         retire_inc;
    logic         taken_inc;

    // Only control instructions can be taken; everything else just steps by 4.
    assign misaligned = (bu_pc[1:0] != 2'b00);
    assign taken      = is_ctrl_reg && (bu_pc != (start_pc_reg + 32'd4));

    // State and per-state registers; reset forces IDLE at any time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= S_IDLE;
            flush_cnt_reg      <= 4'd0;
            fetch_target_reg   <= 32'd0;
            fetch_redirect_reg <= 1'b0;
            wb_data_reg        <= 32'd0;
        end else begin
            state_reg          <= state_next;
            flush_cnt_reg      <= flush_cnt_next;
            fetch_target_reg   <= fetch_target_next;
            fetch_redirect_reg <= fetch_redirect_next;
            wb_data_reg        <= wb_data_next;
        end
    end

    // Next-state logic and one-cycle strobes.
    always_comb begin
        state_next          = state_reg;
        flush_cnt_next      = flush_cnt_reg;
        fetch_target_next   = fetch_target_reg;
        fetch_redirect_next = 1'b0;
        wb_data_next        = wb_data_reg;
        accept              = 1'b0;
        retire_inc          = 1'b0;
        taken_inc           = 1'b0;
        misalign_err        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = S_RESOLVE;
            end
            S_RESOLVE: begin
                if (misaligned) begin
                    misalign_err = 1'b1;
                    state_next   = S_IDLE;
                end else begin
                    retire_inc   = 1'b1;
                    wb_data_next = bu_ret_addr;
                    if (taken) begin
                        taken_inc           = 1'b1;
                        fetch_target_next   = bu_pc;
                        fetch_redirect_next = 1'b1;
                        flush_cnt_next      = FLUSH_LOAD;
                        state_next          = S_FLUSH;
                    end else if (is_link_reg) begin
                        state_next = S_WB;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                flush_cnt_next = flush_cnt_reg - 4'd1;
                if (flush_cnt_reg <= 4'd1) begin
                    state_next = is_link_reg ? S_WB : S_IDLE;
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Capture the accepted instruction, operands and its starting PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_reg    <= '0;
            op1_reg      <= '0;
            op2_reg      <= '0;
            op3_reg      <= '0;
            start_pc_reg <= 32'd0;
            is_link_reg  <= 1'b0;
            is_ctrl_reg  <= 1'b0;
        end else if (accept) begin
            instr_reg    <= in_instr;
            op1_reg      <= in_op1;
            op2_reg      <= in_op2;
            op3_reg      <= in_op3;
            start_pc_reg <= bu_pc;
            is_link_reg  <= is_link(in_instr);
            is_ctrl_reg  <= is_ctrl(in_instr);
        end
    end

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire_inc),
        .clr   (1'b0),
        .count (retire_cnt)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (taken_inc),
        .clr   (1'b0),
        .count (taken_cnt)
    );

    // in_ready is gated by rst_n so it reads 0 while reset is held.
    assign in_ready       = rst_n && (state_reg == S_IDLE);
    assign bu_enable      = (state_reg == S_ISSUE);
    assign fetch_flush    = (state_reg == S_FLUSH);
    assign wb_valid       = (state_reg == S_WB);
    assign fetch_redirect = fetch_redirect_reg;
    assign fetch_target   = fetch_target_reg;
    assign bu_instr       = instr_reg;
    assign bu_op1         = op1_reg;
    assign bu_op2         = op2_reg;
    assign bu_op3         = op3_reg;
    assign wb_rd          = instr_reg[11:7];
    assign wb_data        = wb_data_reg;

endmodule

// File: tb/tb_branch_seq.sv
// Directed testbench for branch_seq; the bench plays the part of branch_unit.
module tb_branch_seq;
    import opcodes::*;

    localparam logic [31:0] I_XOR  = 32'h0020_C1B3; // xor  x3,x1,x2
    localparam logic [31:0] I_JAL1 = 32'h0000_00EF; // jal  x1
    localparam logic [31:0] I_BEQ  = 32'h0020_8063; // beq  x1,x2
    localparam logic [31:0] I_BNE  = 32'h0020_9063; // bne  x1,x2
    localparam logic [31:0] I_JALR = 32'h0000_82E7; // jalr x5,x1

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0, in_op1 = '0, in_op2 = '0, in_op3 = '0;
    logic        bu_enable;
    logic [31:0] bu_instr, bu_op1, bu_op2, bu_op3;
    logic [31:0] bu_pc = '0, bu_ret_addr = '0;
    logic        fetch_redirect;
    logic [31:0] fetch_target;
    logic        fetch_flush;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_err;
    logic [15:0] retire_cnt, taken_cnt;

    int errors = 0;
    int checks = 0;
    logic [31:0] pc = '0;

    branch_seq #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_op1(in_op1), .in_op2(in_op2), .in_op3(in_op3),
        .bu_enable(bu_enable), .bu_instr(bu_instr),
        .bu_op1(bu_op1), .bu_op2(bu_op2), .bu_op3(bu_op3),
        .bu_pc(bu_pc), .bu_ret_addr(bu_ret_addr),
        .fetch_redirect(fetch_redirect), .fetch_target(fetch_target),
        .fetch_flush(fetch_flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_err(misalign_err), .retire_cnt(retire_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one instruction at the current pc, present the resolved pc and
    // return address for RESOLVE, and leave the bench in cycle 3.
    task automatic issue(input logic [31:0] instr, input logic [31:0] op1,
                         input logic [31:0] op2, input logic [31:0] op3,
                         input logic [31:0] nxt, input logic [31:0] ret,
                         input logic exp_mis);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        bu_pc    = pc;
        in_instr = instr;
        in_op1   = op1;
        in_op2   = op2;
        in_op3   = op3;
        in_valid = 1'b1;
        step();                                   // cycle 1: ISSUE
        in_valid = 1'b0;
        check("bu_enable_c1", 32'(bu_enable), 32'd1);
        check("in_ready_c1", 32'(in_ready), 32'd0);
        check("bu_instr", bu_instr, instr);
        check("bu_op3", bu_op3, op3);
        bu_pc       = nxt;
        bu_ret_addr = ret;
        step();                                   // cycle 2: RESOLVE
        check("bu_enable_c2", 32'(bu_enable), 32'd0);
        check("misalign_c2", 32'(misalign_err), 32'(exp_mis));
        step();                                   // cycle 3
        $display("txn instr=0x%08h start_pc=0x%08h resolved=0x%08h redirect=%0b flush=%0b wb_valid=%0b retire=%0d taken=%0d",
                 instr, pc, nxt, fetch_redirect, fetch_flush, wb_valid, retire_cnt, taken_cnt);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_bu_enable", 32'(bu_enable), 32'd0);
        check("rst_retire", 32'(retire_cnt), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // Ten XOR no-ops, three cycles each
        for (int i = 0; i < 10; i++) begin
            issue(I_XOR, 32'd1, 32'd2, 32'd0, pc + 32'd4, pc + 32'd4, 1'b0);
            check("xor_redirect", 32'(fetch_redirect), 32'd0);
            check("xor_flush", 32'(fetch_flush), 32'd0);
            check("xor_ready_c3", 32'(in_ready), 32'd1);
            pc = pc + 32'd4;
        end
        check("xor_retire", 32'(retire_cnt), 32'd10);
        check("xor_taken", 32'(taken_cnt), 32'd0);

        // JAL x1 to 0x00020000 from pc 0x28: link value 0x2C
        issue(I_JAL1, 32'd0, 32'd0, 32'h0001_FFD8, 32'h0002_0000, 32'h0000_002C, 1'b0);
        check("jal_redirect_c3", 32'(fetch_redirect), 32'd1);
        check("jal_target", fetch_target, 32'h0002_0000);
        check("jal_flush_c3", 32'(fetch_flush), 32'd1);
        step();
        check("jal_redirect_c4", 32'(fetch_redirect), 32'd0);
        check("jal_flush_c4", 32'(fetch_flush), 32'd1);
        step();
        check("jal_flush_c5", 32'(fetch_flush), 32'd0);
        check("jal_wb_valid", 32'(wb_valid), 32'd1);
        check("jal_wb_rd", 32'(wb_rd), 32'd1);
        check("jal_wb_data", wb_data, 32'h0000_002C);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        check("jal_wb_done", 32'(wb_valid), 32'd0);
        check("jal_retire", 32'(retire_cnt), 32'd11);
        check("jal_taken", 32'(taken_cnt), 32'd1);
        pc = 32'h0002_0000;

        // BEQ taken: 0x20000 + 0x100
        issue(I_BEQ, 32'd1, 32'd1, 32'h0000_0100, 32'h0002_0100, 32'h0002_0004, 1'b0);
        check("beq_redirect", 32'(fetch_redirect), 32'd1);
        check("beq_target", fetch_target, 32'h0002_0100);
        step();
        check("beq_flush_c4", 32'(fetch_flush), 32'd1);
        step();
        check("beq_flush_c5", 32'(fetch_flush), 32'd0);
        check("beq_no_wb", 32'(wb_valid), 32'd0);
        check("beq_taken", 32'(taken_cnt), 32'd2);
        pc = 32'h0002_0100;

        // BNE not taken
        issue(I_BNE, 32'd5, 32'd5, 32'h0000_0100, 32'h0002_0104, 32'h0002_0104, 1'b0);
        check("bne_redirect", 32'(fetch_redirect), 32'd0);
        check("bne_flush", 32'(fetch_flush), 32'd0);
        check("bne_ready", 32'(in_ready), 32'd1);
        check("bne_retire", 32'(retire_cnt), 32'd13);
        check("bne_taken", 32'(taken_cnt), 32'd2);
        pc = 32'h0002_0104;

        // JALR x5 to 0x30000 with a six-cycle writeback stall
        issue(I_JALR, 32'h0003_0000, 32'd0, 32'd0, 32'h0003_0000, 32'h0002_0108, 1'b0);
        check("jalr_redirect", 32'(fetch_redirect), 32'd1);
        step();
        step();
        in_valid = 1'b1;
        in_instr = I_XOR;
        for (int i = 0; i < 6; i++) begin
            check("jalr_wb_valid", 32'(wb_valid), 32'd1);
            check("jalr_wb_rd", 32'(wb_rd), 32'd5);
            check("jalr_wb_data", wb_data, 32'h0002_0108);
            check("jalr_ready_low", 32'(in_ready), 32'd0);
            check("jalr_no_issue", 32'(bu_enable), 32'd0);
            step();
        end
        in_valid = 1'b0;
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        check("jalr_wb_done", 32'(wb_valid), 32'd0);
        check("jalr_ready", 32'(in_ready), 32'd1);
        check("jalr_retire", 32'(retire_cnt), 32'd14);
        check("jalr_taken", 32'(taken_cnt), 32'd3);
        pc = 32'h0003_0000;

        // Misaligned resolution on a linking jump: no redirect, no writeback
        issue(I_JAL1, 32'd0, 32'd0, 32'd0, 32'h0000_0102, 32'h0003_0004, 1'b1);
        check("mis_pulse_gone", 32'(misalign_err), 32'd0);
        check("mis_redirect", 32'(fetch_redirect), 32'd0);
        check("mis_flush", 32'(fetch_flush), 32'd0);
        check("mis_wb", 32'(wb_valid), 32'd0);
        check("mis_retire", 32'(retire_cnt), 32'd14);
        check("mis_taken", 32'(taken_cnt), 32'd3);

        // Reset asserted mid-FLUSH
        issue(I_BEQ, 32'd1, 32'd1, 32'h0000_0200, 32'h0003_0200, 32'd0, 1'b0);
        check("rf_flush_before", 32'(fetch_flush), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rf_flush", 32'(fetch_flush), 32'd0);
        check("rf_redirect", 32'(fetch_redirect), 32'd0);
        check("rf_target", fetch_target, 32'd0);
        check("rf_ready", 32'(in_ready), 32'd0);
        check("rf_bu_instr", bu_instr, 32'd0);
        check("rf_retire", 32'(retire_cnt), 32'd0);
        check("rf_taken", 32'(taken_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("rf_release_ready", 32'(in_ready), 32'd1);
        pc = 32'd0;
        issue(I_XOR, 32'd1, 32'd2, 32'd0, 32'd4, 32'd4, 1'b0);
        check("rf_after_ready", 32'(in_ready), 32'd1);
        check("rf_after_retire", 32'(retire_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the bench always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
